// File: rtl/quiz_result_scoreboard_pkg.sv
// Shared definitions for the quiz result scoreboard.
// Holds the quiz-family default widths and the scoreboard state encoding.
// The encoding is fixed so it matches the rest of the quiz harness:
// IDLE=0, RUN=1, DONE=2.
package quiz_result_scoreboard_pkg;

    // Default widths for the quiz family: a 2-to-4 decoder under test.
    localparam int DEF_IN_W    = 2;
    localparam int DEF_OUT_W   = 4;
    localparam int DEF_NUM_VEC = 16;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/quiz_result_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset (count -> 0)
//   clear - synchronous clear, takes priority over en
//   en    - increment by one when not already at all-ones
//   count - current count, sticks at 2**W-1 instead of wrapping
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/quiz_result_scoreboard.sv
// Quiz result scoreboard.
// Compares the golden decoder output against the student decoder output for a
// fixed-length window of NUM_VEC valid vectors. It counts matches and
// mismatches, remembers the first failing vector, and reports a pass/fail
// verdict once the window is complete.
// Ports:
//   sys_clk, sys_rst       - clock and synchronous active-high reset
//   start                  - one-cycle request to open a window (ignored in RUN)
//   vec_valid              - vec_in/b_true/b_test are valid this cycle
//   vec_in, b_true, b_test - stimulus, golden output, student output
//   busy, done, pass       - window running / window finished / zero mismatches
//   match_cnt, mismatch_cnt- saturating result counters
//   fail_seen, first_fail_*- capture of the first mismatching vector
module quiz_result_scoreboard
    import quiz_result_scoreboard_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int NUM_VEC = DEF_NUM_VEC,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [IN_W-1:0]  vec_in,
    input  logic [OUT_W-1:0] b_true,
    input  logic [OUT_W-1:0] b_test,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             fail_seen,
    output logic [IN_W-1:0]  first_fail_vec,
    output logic [OUT_W-1:0] first_fail_true,
    output logic [OUT_W-1:0] first_fail_test
);

    // Sample count value on which the final sample of the window is taken.
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(NUM_VEC - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] sample_cnt;
    logic             start_window;
    logic             sample_en;
    logic             is_match;

    // A window can only be opened from IDLE or DONE; a start seen while
    // running is dropped. Sampling only happens in RUN, so a vector that
    // arrives together with start is never counted.
    assign start_window = start && (state != ST_RUN);
    assign sample_en    = vec_valid && (state == ST_RUN);

    // An unknown comparison result falls into the else branch, so X/Z on
    // b_test is scored as a mismatch.
    always_comb begin
        is_match = 1'b0;
        if (b_true == b_test) begin
            is_match = 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RUN ends on the same edge that takes the last sample, so done rises
    // one cycle after the final valid vector.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (sample_en && (sample_cnt == LAST_SAMPLE)) state_next = ST_DONE;
            ST_DONE: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    // Sample counter plus first-failure capture. Only the first mismatch of
    // a window is latched; later ones leave the captured fields alone.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || start_window) begin
            sample_cnt      <= '0;
            fail_seen       <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_true <= '0;
            first_fail_test <= '0;
        end else if (sample_en) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (!is_match && !fail_seen) begin
                fail_seen       <= 1'b1;
                first_fail_vec  <= vec_in;
                first_fail_true <= b_true;
                first_fail_test <= b_test;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clear (start_window),
        .en    (sample_en && is_match),
        .count (match_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clear (start_window),
        .en    (sample_en && !is_match),
        .count (mismatch_cnt)
    );

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign pass = done && (mismatch_cnt == '0);

endmodule
